// File: rtl/td4_pkg.sv
// Shared types and sizes for the TD4 run controller and its program memory.
package td4_pkg;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 16;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HALT = 2'd1,
    RUN  = 2'd2,
    STEP = 2'd3
  } ctrl_state_t;
endpackage

// File: rtl/td4_run_ctrl_if.sv
// Host/CPU facing bundle of the run controller.
//   ld_*        : program-load port (valid/ready + done pulse)
//   cmd_*       : one-cycle command pulses from buttons/host
//   cpu_address : CPU fetch address; cpu_data returns the instruction byte
//   cpu_reset   : CPU reset, cpu_en: per-instruction clock enable
//   state       : current controller state for LEDs/debug
// master = host/CPU side, slave = controller side.
interface td4_run_ctrl_if;
  import td4_pkg::*;
  logic                ld_valid;
  logic                ld_ready;
  logic [ADDR_W-1:0]   ld_addr;
  logic [DATA_W-1:0]   ld_data;
  logic                ld_done;
  logic                cmd_load;
  logic                cmd_run;
  logic                cmd_halt;
  logic                cmd_step;
  logic [ADDR_W-1:0]   cpu_address;
  logic [DATA_W-1:0]   cpu_data;
  logic                cpu_reset;
  logic                cpu_en;
  logic [1:0]          state;

  modport master (
    output ld_valid, ld_addr, ld_data, ld_done,
    output cmd_load, cmd_run, cmd_halt, cmd_step, cpu_address,
    input  ld_ready, cpu_data, cpu_reset, cpu_en, state
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_done,
    input  cmd_load, cmd_run, cmd_halt, cmd_step, cpu_address,
    output ld_ready, cpu_data, cpu_reset, cpu_en, state
  );
endinterface

// File: rtl/td4_run_ctrl_prog_mem.sv
// 16x8 program memory: synchronous write, asynchronous read, synchronous
// active-low clear of every byte.
//   clock   : system clock
//   clr_n_i : clear all bytes to zero at the edge (wins over a write)
//   we_i    : write enable, waddr_i/wdata_i written at the edge
//   raddr_i : read address, rdata_o follows combinationally
module prog_mem
  import td4_pkg::*;
(
  input  logic              clock,
  input  logic              clr_n_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [MEM_DEPTH-1:0][DATA_W-1:0] mem_q;

  always_ff @(posedge clock) begin
    if (!clr_n_i) begin
      mem_q <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/td4_run_ctrl.sv
// Run controller for the TD4 CPU: owns program memory, sequences the CPU
// through LOAD / HALT / STEP / RUN by driving its reset and clock enable.
//   clock : system clock
//   reset : synchronous active-low reset (state LOAD, memory cleared)
//   bus   : td4_run_ctrl_if.slave (load port, commands, CPU fetch/control)
// RUN_DIV : clock cycles per instruction in RUN (>= 1)
// CNT_W   : divider width, 2**CNT_W >= RUN_DIV
module td4_run_ctrl
  import td4_pkg::*;
#(
  parameter int RUN_DIV = 12000000,
  parameter int CNT_W   = 24
) (
  input  logic          clock,
  input  logic          reset,
  td4_run_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] TC = CNT_W'(RUN_DIV - 1);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc;
  logic             mem_we;

  assign tc = (cnt_q == TC);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LOAD: if (bus.ld_done) state_d = HALT;
      HALT: begin
        if (bus.cmd_load)      state_d = LOAD;
        else if (bus.cmd_step) state_d = STEP;
        else if (bus.cmd_run) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      STEP: state_d = HALT;
      RUN: begin
        // Divider free-runs; a command on the terminal-count cycle still lets
        // that cycle's enable through because cpu_en is decoded from cnt_q.
        cnt_d = tc ? '0 : cnt_q + 1'b1;
        if (bus.cmd_load) state_d = LOAD;
        else if (bus.cmd_halt) begin
          state_d = HALT;
          cnt_d   = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Writes only land in LOAD; reset clears memory and drops any write.
  assign mem_we = bus.ld_valid && (state_q == LOAD);

  prog_mem u_mem (
    .clock   (clock),
    .clr_n_i (reset),
    .we_i    (mem_we),
    .waddr_i (bus.ld_addr),
    .wdata_i (bus.ld_data),
    .raddr_i (bus.cpu_address),
    .rdata_o (bus.cpu_data)
  );

  assign bus.cpu_reset = (state_q == LOAD);
  assign bus.ld_ready  = (state_q == LOAD);
  assign bus.cpu_en    = (state_q == STEP) || ((state_q == RUN) && tc);
  assign bus.state     = state_q;
endmodule

// File: tb/tb_td4_run_ctrl.sv
module tb_td4_run_ctrl;
  import td4_pkg::*;

  localparam logic [3:0] C_NONE = 4'b0000;
  localparam logic [3:0] C_LOAD = 4'b1000;
  localparam logic [3:0] C_RUN  = 4'b0100;
  localparam logic [3:0] C_HALT = 4'b0010;
  localparam logic [3:0] C_STEP = 4'b0001;

  typedef struct {
    logic        rst;
    logic        lv;
    logic [3:0]  la;
    logic [7:0]  ld;
    logic        dn;
    logic [3:0]  cmd;
    logic [3:0]  ca;
    ctrl_state_t st;
    logic        en;
    logic [7:0]  dat;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  td4_run_ctrl_if bus();

  td4_run_ctrl #(.RUN_DIV(4), .CNT_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic lv, input logic [3:0] la,
                     input logic [7:0] ldat, input logic dn, input logic [3:0] cmd,
                     input logic [3:0] ca, input ctrl_state_t st, input logic en,
                     input logic [7:0] dat);
    vec_t v;
    v.rst = rst; v.lv = lv; v.la = la; v.ld = ldat; v.dn = dn; v.cmd = cmd;
    v.ca = ca; v.st = st; v.en = en; v.dat = dat;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset           = v.rst;
    bus.ld_valid    = v.lv;
    bus.ld_addr     = v.la;
    bus.ld_data     = v.ld;
    bus.ld_done     = v.dn;
    bus.cmd_load    = v.cmd[3];
    bus.cmd_run     = v.cmd[2];
    bus.cmd_halt    = v.cmd[1];
    bus.cmd_step    = v.cmd[0];
    bus.cpu_address = v.ca;
  endtask

  task automatic idle_inputs();
    vec_t v;
    v.rst = 1'b1; v.lv = 1'b0; v.la = '0; v.ld = '0; v.dn = 1'b0;
    v.cmd = C_NONE; v.ca = '0; v.st = LOAD; v.en = 1'b0; v.dat = '0;
    drive(v);
  endtask

  initial begin
    vec_t got;
    int   k, first, gap;

    // Reset state and cleared memory.
    add(0, 0, 0, 8'h00, 0, C_NONE, 0, LOAD, 0, 8'h00);
    for (int a = 0; a < 16; a++) add(1, 0, 0, 8'h00, 0, C_NONE, 4'(a), LOAD, 0, 8'h00);
    // Load with same-address overwrite; commands ignored in LOAD.
    add(1, 1, 0, 8'h31, 0, C_NONE, 0, LOAD, 0, 8'h00);
    add(1, 1, 1, 8'h05, 0, C_NONE, 0, LOAD, 0, 8'h31);
    add(1, 1, 0, 8'hB3, 0, C_NONE, 1, LOAD, 0, 8'h05);
    add(1, 0, 0, 8'h00, 1, C_RUN | C_STEP, 0, LOAD, 0, 8'hB3);
    add(1, 0, 0, 8'h00, 0, C_NONE, 1, HALT, 0, 8'h05);
    add(1, 0, 0, 8'h00, 0, C_NONE, 0, HALT, 0, 8'hB3);
    // Single step; step beats run; commands ignored during STEP.
    add(1, 0, 0, 8'h00, 0, C_STEP, 0, HALT, 0, 8'hB3);
    add(1, 0, 0, 8'h00, 0, C_NONE, 0, STEP, 1, 8'hB3);
    add(1, 0, 0, 8'h00, 0, C_NONE, 0, HALT, 0, 8'hB3);
    add(1, 0, 0, 8'h00, 0, C_STEP | C_RUN, 0, HALT, 0, 8'hB3);
    add(1, 0, 0, 8'h00, 0, C_STEP | C_RUN, 0, STEP, 1, 8'hB3);
    add(1, 0, 0, 8'h00, 0, C_NONE, 0, HALT, 0, 8'hB3);
    add(1, 0, 0, 8'h00, 0, C_NONE, 0, HALT, 0, 8'hB3);
    // Run, halt on the terminal-count cycle 8.
    add(1, 0, 0, 8'h00, 0, C_RUN, 0, HALT, 0, 8'hB3);
    for (int c = 1; c <= 8; c++)
      add(1, 0, 0, 8'h00, 0, (c == 8) ? C_HALT : (c == 2) ? (C_STEP | C_RUN) : C_NONE,
          0, RUN, (c % 4) == 0, 8'hB3);
    for (int c = 0; c < 4; c++) add(1, 0, 0, 8'h00, 0, C_NONE, 0, HALT, 0, 8'hB3);
    // Run again: pulses on 4, 8, 12, then halt.
    add(1, 0, 0, 8'h00, 0, C_RUN, 0, HALT, 0, 8'hB3);
    for (int c = 1; c <= 13; c++)
      add(1, 0, 0, 8'h00, 0, (c == 13) ? C_HALT : C_NONE, 0, RUN, (c % 4) == 0, 8'hB3);
    add(1, 0, 0, 8'h00, 0, C_NONE, 0, HALT, 0, 8'hB3);
    // Writes ignored outside LOAD, accepted after cmd_load.
    add(1, 1, 3, 8'hFF, 0, C_NONE, 3, HALT, 0, 8'h00);
    add(1, 1, 3, 8'hFF, 0, C_NONE, 3, HALT, 0, 8'h00);
    add(1, 1, 3, 8'hFF, 0, C_LOAD, 3, HALT, 0, 8'h00);
    add(1, 1, 3, 8'hFF, 0, C_NONE, 3, LOAD, 0, 8'h00);
    add(1, 0, 0, 8'h00, 0, C_NONE, 3, LOAD, 0, 8'hFF);
    add(1, 0, 0, 8'h00, 1, C_NONE, 3, LOAD, 0, 8'hFF);
    add(1, 0, 0, 8'h00, 0, C_NONE, 0, HALT, 0, 8'hB3);
    // Reset mid-RUN on the terminal count.
    add(1, 0, 0, 8'h00, 0, C_RUN, 0, HALT, 0, 8'hB3);
    for (int c = 1; c <= 3; c++) add(1, 0, 0, 8'h00, 0, C_NONE, 0, RUN, 0, 8'hB3);
    add(0, 0, 0, 8'h00, 0, C_NONE, 0, RUN, 1, 8'hB3);
    for (int a = 0; a < 16; a++) add(1, 0, 0, 8'h00, 0, C_NONE, 4'(a), LOAD, 0, 8'h00);
    // Reset mid-LOAD drops the write.
    add(0, 1, 5, 8'hAA, 0, C_NONE, 5, LOAD, 0, 8'h00);
    add(1, 0, 0, 8'h00, 0, C_NONE, 5, LOAD, 0, 8'h00);
    add(1, 1, 5, 8'hAA, 0, C_NONE, 5, LOAD, 0, 8'h00);
    add(1, 0, 0, 8'h00, 1, C_NONE, 5, LOAD, 0, 8'hAA);
    // Divider restarts from 0; cmd_load leaves memory intact.
    add(1, 0, 0, 8'h00, 0, C_RUN, 5, HALT, 0, 8'hAA);
    for (int c = 1; c <= 5; c++)
      add(1, 0, 0, 8'h00, 0, (c == 5) ? (C_LOAD | C_HALT) : C_NONE, 5, RUN, c == 4, 8'hAA);
    add(1, 0, 0, 8'h00, 0, C_NONE, 5, LOAD, 0, 8'hAA);

    // Bring-up: hold reset for two edges.
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clock);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clock);
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      #1;
      got = exp_q.pop_front();
      chk($sformatf("row%0d state", i), 32'(bus.state), 32'(got.st));
      chk($sformatf("row%0d cpu_en", i), 32'(bus.cpu_en), 32'(got.en));
      chk($sformatf("row%0d cpu_reset", i), 32'(bus.cpu_reset), 32'(got.st == LOAD));
      chk($sformatf("row%0d ld_ready", i), 32'(bus.ld_ready), 32'(got.st == LOAD));
      chk($sformatf("row%0d cpu_data", i), 32'(bus.cpu_data), 32'(got.dat));
    end

    // Hand sequence: measure first-pulse latency and pulse period in RUN.
    @(negedge clock); idle_inputs(); bus.ld_done = 1'b1;
    @(negedge clock); idle_inputs(); bus.cmd_run = 1'b1;
    @(negedge clock); idle_inputs();
    k = 1; first = -1; gap = -1;
    while (k < 20 && gap < 0) begin
      #1;
      if (bus.cpu_en) begin
        if (first < 0) first = k;
        else gap = k - first;
      end
      @(negedge clock);
      k++;
    end
    chk("run first pulse latency", 32'(first), 32'd4);
    chk("run pulse period", 32'(gap), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
